// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: Wishbone slave side, LA host side and SRAM macro side.
// slave modport = the arbiter's view; master modport = the surrounding wrapper / bench view.
// Ports: wbs_* (Wishbone classic slave), la_* (level request host), mem_* (single-port SRAM).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Wishbone slave bus
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    // Logic-analyzer host
    logic              la_req_i;
    logic              la_we_i;
    logic [ADDR_W-1:0] la_addr_i;
    logic [31:0]       la_wdata_i;
    logic              la_ack_o;
    logic [31:0]       la_rdata_o;
    // SRAM macro port
    logic              mem_csb_o;
    logic              mem_web_o;
    logic [3:0]        mem_wmask_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_din_o;
    logic [31:0]       mem_dout_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  la_req_i, la_we_i, la_addr_i, la_wdata_i,
        output la_ack_o, la_rdata_o,
        output mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o,
        input  mem_dout_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output la_req_i, la_we_i, la_addr_i, la_wdata_i,
        input  la_ack_o, la_rdata_o,
        input  mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o,
        output mem_dout_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the Wishbone slave bus and the LA host.
// Latency from request seen in IDLE: write ack +2, read ack +2+MEM_LAT, out-of-window ack +1.
// Backpressure: one transfer in flight; requests are only sampled in IDLE, losers keep waiting.
// Ports: wb_clk_i / wb_rst_ni (async active-low), bus (mem_port_arbiter_if.slave), arb_busy_o.
// Option: define ARB_WB_PRIORITY_EN for fixed WB-wins-ties priority instead of round-robin.
module mem_port_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter int          MEM_LAT   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    mem_port_arbiter_if.slave     bus,
    output logic                  arb_busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              own_wb_q, own_wb_d;     // 1: current transfer belongs to WB
    logic              abort_q, abort_d;       // WB dropped cyc mid-transfer
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifndef ARB_WB_PRIORITY_EN
    logic              last_wb_q, last_wb_d;   // last grant went to WB
`endif
    logic              wbs_ack_q, wbs_ack_d;
    logic              la_ack_q, la_ack_d;
    logic [31:0]       wbs_dat_q, wbs_dat_d;
    logic [31:0]       la_rdata_q, la_rdata_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;

    logic wb_req;
    logic in_win;
    logic grant_wb;
    logic abort_now;
    logic unused_adr;

    assign wb_req     = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign in_win     = (bus.wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    // Abort includes a cyc drop in the very cycle the ack decision is made.
    assign abort_now  = abort_q | (own_wb_q & ~bus.wbs_cyc_i);
    assign unused_adr = &{1'b0, bus.wbs_adr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        own_wb_d   = own_wb_q;
        abort_d    = abort_q;
        cnt_d      = cnt_q;
`ifndef ARB_WB_PRIORITY_EN
        last_wb_d  = last_wb_q;
`endif
        wbs_ack_d  = 1'b0;
        la_ack_d   = 1'b0;
        wbs_dat_d  = '0;
        la_rdata_d = la_rdata_q;
        csb_d      = 1'b1;
        web_d      = web_q;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        grant_wb   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_req || bus.la_req_i) begin
`ifdef ARB_WB_PRIORITY_EN
                    grant_wb = wb_req;
`else
                    // Tie goes to whoever did not win last time.
                    grant_wb  = wb_req && (!bus.la_req_i || !last_wb_q);
                    last_wb_d = grant_wb;
`endif
                    own_wb_d = grant_wb;
                    abort_d  = 1'b0;
                    if (grant_wb && !in_win) begin
                        // Outside the SRAM window: answer immediately with zero data.
                        state_d   = RESP;
                        wbs_ack_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        csb_d   = 1'b0;
                        if (grant_wb) begin
                            web_d   = ~bus.wbs_we_i;
                            addr_d  = bus.wbs_adr_i[ADDR_W+1:2];
                            din_d   = bus.wbs_dat_i;
                            wmask_d = bus.wbs_sel_i;
                        end else begin
                            web_d   = ~bus.la_we_i;
                            addr_d  = bus.la_addr_i;
                            din_d   = bus.la_wdata_i;
                            wmask_d = 4'hF;
                        end
                    end
                end
            end
            ISSUE: begin
                abort_d = abort_now;
                if (!web_q) begin
                    state_d = RESP;
                    if (own_wb_q) wbs_ack_d = ~abort_now;
                    else          la_ack_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                abort_d = abort_now;
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    if (own_wb_q) begin
                        wbs_ack_d = ~abort_now;
                        wbs_dat_d = abort_now ? 32'h0 : bus.mem_dout_i;
                    end else begin
                        la_ack_d   = 1'b1;
                        la_rdata_d = bus.mem_dout_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            own_wb_q   <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= '0;
`ifndef ARB_WB_PRIORITY_EN
            last_wb_q  <= 1'b0;
`endif
            wbs_ack_q  <= 1'b0;
            la_ack_q   <= 1'b0;
            wbs_dat_q  <= '0;
            la_rdata_q <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            own_wb_q   <= own_wb_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
`ifndef ARB_WB_PRIORITY_EN
            last_wb_q  <= last_wb_d;
`endif
            wbs_ack_q  <= wbs_ack_d;
            la_ack_q   <= la_ack_d;
            wbs_dat_q  <= wbs_dat_d;
            la_rdata_q <= la_rdata_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign bus.wbs_ack_o   = wbs_ack_q;
    assign bus.wbs_dat_o   = wbs_dat_q;
    assign bus.la_ack_o    = la_ack_q;
    assign bus.la_rdata_o  = la_rdata_q;
    assign bus.mem_csb_o   = csb_q;
    assign bus.mem_web_o   = web_q;
    assign bus.mem_wmask_o = wmask_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_din_o   = din_q;
    assign arb_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency SRAM model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived cycle by cycle from the request cycle N.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(10)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (10),
        .MEM_LAT  (1),
        .BASE_ADDR(32'h3000_0000)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .arb_busy_o(busy)
    );

`ifdef ARB_WB_PRIORITY_EN
    localparam bit EXP_LA_FIRST = 1'b0;
`else
    localparam bit EXP_LA_FIRST = 1'b1;
`endif

    // SRAM model: samples on the edge where csb is low, read data valid the next cycle.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (!bus.mem_csb_o) begin
            if (!bus.mem_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask_o[b])
                        sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_din_o[8*b +: 8];
            end else begin
                bus.mem_dout_i <= sram[bus.mem_addr_o];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic wb_drop();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
    endtask

    task automatic la_start(input logic we, input logic [9:0] addr, input logic [31:0] dat);
        bus.la_req_i   = 1'b1;
        bus.la_we_i    = we;
        bus.la_addr_i  = addr;
        bus.la_wdata_i = dat;
    endtask

    logic [5:0] order;
    int         grants;
    int         wb_off;
    int         la_off;
    logic       ack_seen;

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
        bus.mem_dout_i = 32'h0;
        wb_drop();
        bus.wbs_we_i   = 1'b0;
        bus.wbs_sel_i  = 4'h0;
        bus.wbs_adr_i  = 32'h0;
        bus.wbs_dat_i  = 32'h0;
        bus.la_req_i   = 1'b0;
        bus.la_we_i    = 1'b0;
        bus.la_addr_i  = 10'h0;
        bus.la_wdata_i = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_csb",    bus.mem_csb_o,  1);
        chk("rst_web",    bus.mem_web_o,  1);
        chk("rst_acks",   {bus.wbs_ack_o, bus.la_ack_o}, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_wbdat",  bus.wbs_dat_o,  0);
        chk("rst_laread", bus.la_rdata_o, 0);
        chk("rst_addr",   {bus.mem_wmask_o, bus.mem_addr_o}, 0);
        rst_n = 1'b1;
        step();

        // WB write 0x3000_0010 <- DEADBEEF
        wb_start(1'b1, 32'h3000_0010, 32'hDEAD_BEEF);
        step();
        chk("wr_csb",   bus.mem_csb_o, 0);
        chk("wr_web",   bus.mem_web_o, 0);
        chk("wr_addr",  bus.mem_addr_o, 4);
        chk("wr_wmask", bus.mem_wmask_o, 4'hF);
        chk("wr_din",   bus.mem_din_o, 32'hDEAD_BEEF);
        chk("wr_busy",  busy, 1);
        chk("wr_noack", bus.wbs_ack_o, 0);
        step();
        chk("wr_ack",   bus.wbs_ack_o, 1);
        chk("wr_csb2",  bus.mem_csb_o, 1);
        wb_drop();
        step();
        chk("wr_ack_pulse", bus.wbs_ack_o, 0);
        chk("wr_idle",      busy, 0);

        // WB read 0x3000_0010
        wb_start(1'b0, 32'h3000_0010, 32'h0);
        step();
        chk("rd_csb", bus.mem_csb_o, 0);
        chk("rd_web", bus.mem_web_o, 1);
        step();
        chk("rd_wait_noack", bus.wbs_ack_o, 0);
        chk("rd_wait_csb",   bus.mem_csb_o, 1);
        step();
        chk("rd_ack", bus.wbs_ack_o, 1);
        chk("rd_dat", bus.wbs_dat_o, 32'hDEAD_BEEF);
        wb_drop();
        step();
        chk("rd_ack_pulse", bus.wbs_ack_o, 0);

        // Out-of-window read
        wb_start(1'b0, 32'h3100_0000, 32'h0);
        step();
        chk("oow_ack", bus.wbs_ack_o, 1);
        chk("oow_dat", bus.wbs_dat_o, 0);
        chk("oow_csb", bus.mem_csb_o, 1);
        wb_drop();
        step();
        chk("oow_ack_pulse", bus.wbs_ack_o, 0);
        chk("oow_csb2",      bus.mem_csb_o, 1);
        chk("oow_idle",      busy, 0);

        // WB read aborted during WAIT, then LA read of the same word
        wb_start(1'b0, 32'h3000_0010, 32'h0);
        step();
        chk("abt_csb", bus.mem_csb_o, 0);
        step();
        wb_drop();
        chk("abt_csb_once", bus.mem_csb_o, 1);
        step();
        chk("abt_noack", bus.wbs_ack_o, 0);
        chk("abt_csb_resp", bus.mem_csb_o, 1);
        step();
        chk("abt_noack2", bus.wbs_ack_o, 0);
        chk("abt_idle",   busy, 0);
        la_start(1'b0, 10'd4, 32'h0);
        step();
        chk("la_csb",  bus.mem_csb_o, 0);
        chk("la_addr", bus.mem_addr_o, 4);
        chk("la_web",  bus.mem_web_o, 1);
        step();
        chk("la_wait_noack", bus.la_ack_o, 0);
        step();
        chk("la_ack",   bus.la_ack_o, 1);
        chk("la_rdata", bus.la_rdata_o, 32'hDEAD_BEEF);
        bus.la_req_i = 1'b0;
        step();
        chk("la_ack_pulse", bus.la_ack_o, 0);
        chk("la_rdata_hold", bus.la_rdata_o, 32'hDEAD_BEEF);

        // Both requesting continuously (writes); each drops for one cycle after its ack
        order  = 6'h0;
        grants = 0;
        wb_off = 0;
        la_off = 0;
        wb_start(1'b1, 32'h3000_0020, 32'h1111_0000);
        la_start(1'b1, 10'd9, 32'h2222_0000);
        for (int c = 0; c < 80 && grants < 6; c++) begin
            step();
            if (wb_off > 0) begin
                wb_off--;
                if (wb_off == 0) wb_start(1'b1, 32'h3000_0020, 32'h1111_0000 + grants);
            end
            if (la_off > 0) begin
                la_off--;
                if (la_off == 0) la_start(1'b1, 10'd9, 32'h2222_0000 + grants);
            end
            if (bus.wbs_ack_o && grants < 6) begin
                order[grants] = 1'b1;
                grants++;
                wb_drop();
                wb_off = 2;
            end
            if (bus.la_ack_o && grants < 6) begin
                order[grants] = 1'b0;
                grants++;
                bus.la_req_i = 1'b0;
                la_off = 2;
            end
        end
        wb_drop();
        bus.la_req_i = 1'b0;
        chk("rr_count", grants, 6);
        chk("rr_order", {26'h0, order}, 32'h15);
        step();
        step();
        chk("rr_idle", busy, 0);

        // Lone WB write, then a simultaneous tie
        wb_start(1'b1, 32'h3000_0040, 32'h0000_0001);
        step();
        step();
        chk("lone_wb_ack", bus.wbs_ack_o, 1);
        wb_drop();
        step();
        wb_start(1'b1, 32'h3000_0048, 32'h0000_0002);
        la_start(1'b1, 10'd5, 32'h0000_0003);
        step();
        chk("tie_addr", bus.mem_addr_o, EXP_LA_FIRST ? 32'd5 : 32'd18);
        step();
        chk("tie_first_ack", {bus.wbs_ack_o, bus.la_ack_o}, EXP_LA_FIRST ? 2'b01 : 2'b10);
        if (EXP_LA_FIRST) bus.la_req_i = 1'b0;
        else              wb_drop();
        step();
        step();
        step();
        chk("tie_second_ack", {bus.wbs_ack_o, bus.la_ack_o}, EXP_LA_FIRST ? 2'b10 : 2'b01);
        wb_drop();
        bus.la_req_i = 1'b0;
        step();
        step();

        // Reset asserted during a read's WAIT
        wb_start(1'b0, 32'h3000_0010, 32'h0);
        step();
        chk("rstw_issue_csb", bus.mem_csb_o, 0);
        step();
        chk("rstw_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_csb",  bus.mem_csb_o, 1);
        chk("rstw_acks", {bus.wbs_ack_o, bus.la_ack_o}, 0);
        chk("rstw_busy", busy, 0);
        step();
        wb_drop();
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            ack_seen = ack_seen | bus.wbs_ack_o | bus.la_ack_o;
        end
        chk("rstw_no_ack", ack_seen, 0);
        chk("rstw_idle",   busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
